day1_parser: RTL and testbench



---
 rtl/day1_parser_pkg.sv | 30 +++
 rtl/day1_parser_decimal_accumulator.sv | 48 ++++
 rtl/day1_parser.sv | 174 +++++++++++++++++
 tb/tb_day1_parser.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/day1_parser_pkg.sv
// day1_pkg: shared types and constants for the Day 1 byte-stream parser.
//   state_t      - parser FSM states (IDLE, DIGITS, ERROR, DONE)
//   CH_*         - ASCII codes the parser recognises
//   MAG_W        - width of a decoded magnitude
//   MAG_MAX      - saturation value for a magnitude
//   is_digit()   - true for ASCII '0'..'9'
package day1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    ERROR  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] CH_L    = 8'h4C;  // 'L'
  localparam logic [7:0] CH_R    = 8'h52;  // 'R'
  localparam logic [7:0] CH_ZERO = 8'h30;  // '0'
  localparam logic [7:0] CH_NINE = 8'h39;  // '9'
  localparam logic [7:0] CH_LF   = 8'h0A;  // '\n'
  localparam logic [7:0] CH_CR   = 8'h0D;  // '\r'

  localparam int MAG_W = 16;
  localparam logic [MAG_W-1:0] MAG_MAX = 16'hFFFF;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_ZERO) && (b <= CH_NINE);
  endfunction

endpackage

// File: rtl/day1_parser_decimal_accumulator.sv
// decimal_accumulator: saturating base-10 accumulator for one line's digits.
// Ports:
//   clock, clear_n      - clock, asynchronous active-low reset
//   clear               - zero the value and digit count (wins over digit_en)
//   digit_en, digit     - append one decimal digit (0..9)
//   value               - registered accumulated value
//   next_value          - value after appending 'digit' (used when the line
//                         ends on the same byte that carries a digit)
//   count               - digits appended since the last clear
//   overflow            - appending 'digit' saturates the value
module decimal_accumulator
  import day1_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             clear,
  input  logic             digit_en,
  input  logic [3:0]       digit,
  output logic [MAG_W-1:0] value,
  output logic [MAG_W-1:0] next_value,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // 65535*10 + 9 fits in 20 bits, so the product never wraps before the
  // saturation test.
  logic [19:0] wide;

  assign wide       = (20'(value) * 20'd10) + 20'(digit);
  assign overflow   = wide > 20'(MAG_MAX);
  assign next_value = overflow ? MAG_MAX : wide[MAG_W-1:0];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (digit_en) begin
      value <= next_value;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/day1_parser.sv
// day1_parser: decodes an ASCII stream of "L<decimal>" / "R<decimal>" lines
// into {direction, magnitude} instructions with a one-cycle valid pulse.
// Ports:
//   clock, clear_n        - clock, asynchronous active-low reset
//   data_in[7:0]          - ASCII byte
//   data_in_valid         - byte present
//   data_in_last          - final byte of the input (qualified by valid)
//   data_in_ready         - parser accepts a byte this cycle
//   direction             - 1 = R, 0 = L (held between pulses)
//   magnitude[15:0]       - decoded value (held between pulses)
//   instruction_valid     - one-cycle pulse, new instruction present
//   done, error, overflow - sticky status flags
//   instruction_count     - pulses since reset (only with DAY1_PARSER_STATS_EN)
//   state_dbg             - current FSM state, for observation only
// Optional feature macro: DAY1_PARSER_STATS_EN.
//
// Handshake: a byte transfers on a rising edge where data_in_valid and
// data_in_ready are both 1. data_in_ready depends on the state register
// only; it is low solely in DONE. Outputs carry no backpressure.
module day1_parser
  import day1_pkg::*;
#(
  parameter int MAX_DIGITS = 5
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic [7:0]       data_in,
  input  logic             data_in_valid,
  input  logic             data_in_last,
  output logic             data_in_ready,
  output logic             direction,
  output logic [MAG_W-1:0] magnitude,
  output logic             instruction_valid,
  output logic             done,
  output logic             error,
  output logic             overflow,
`ifdef DAY1_PARSER_STATS_EN
  output logic [31:0]      instruction_count,
`endif
  output state_t           state_dbg
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  state_t state_q, state_next, proc_state;

  logic             accept;
  logic             dir_latched;
  logic             emit, set_err, set_ovf, set_done;
  logic             acc_clear, digit_en, dir_load;
  logic [MAG_W-1:0] acc_value, acc_next;
  logic [CNT_W-1:0] acc_count;
  logic             acc_ovf;
  logic [MAG_W-1:0] emit_mag;

  assign data_in_ready = (state_q != DONE);
  assign accept        = data_in_valid & data_in_ready;
  assign state_dbg     = state_q;

  decimal_accumulator #(
    .CNT_W (CNT_W)
  ) u_acc (
    .clock      (clock),
    .clear_n    (clear_n),
    .clear      (acc_clear),
    .digit_en   (digit_en),
    .digit      (data_in[3:0]),
    .value      (acc_value),
    .next_value (acc_next),
    .count      (acc_count),
    .overflow   (acc_ovf)
  );

  // A line ending on a digit byte (data_in_last, no newline) must report the
  // value including that digit, which is not yet in the register.
  assign emit_mag = digit_en ? acc_next : acc_value;

  always_comb begin
    proc_state = state_q;
    state_next = state_q;
    emit       = 1'b0;
    set_err    = 1'b0;
    set_ovf    = 1'b0;
    set_done   = 1'b0;
    acc_clear  = 1'b0;
    digit_en   = 1'b0;
    dir_load   = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if ((data_in == CH_L) || (data_in == CH_R)) begin
            dir_load   = 1'b1;
            acc_clear  = 1'b1;
            proc_state = DIGITS;
          end else if ((data_in == CH_LF) || (data_in == CH_CR)) begin
            proc_state = IDLE;
          end else begin
            proc_state = ERROR;
          end
        end
        DIGITS: begin
          if (is_digit(data_in)) begin
            if (acc_count < MAX_CNT) begin
              digit_en = 1'b1;
              set_ovf  = acc_ovf;
            end else begin
              proc_state = ERROR;
            end
          end else if (data_in == CH_CR) begin
            proc_state = DIGITS;
          end else if (data_in == CH_LF) begin
            if (acc_count != '0) begin
              emit       = 1'b1;
              proc_state = IDLE;
            end else begin
              proc_state = ERROR;
            end
          end else begin
            proc_state = ERROR;
          end
        end
        ERROR:   proc_state = ERROR;
        DONE:    proc_state = DONE;
        default: proc_state = ERROR;
      endcase

      if (proc_state == ERROR) set_err = 1'b1;
      state_next = proc_state;

      // Last byte: finish the pending line (if any) in the same update.
      if (data_in_last) begin
        state_next = DONE;
        set_done   = 1'b1;
        if (proc_state == DIGITS) begin
          if (digit_en || (!acc_clear && (acc_count != '0))) emit = 1'b1;
          else set_err = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q           <= IDLE;
      dir_latched       <= 1'b0;
      direction         <= 1'b0;
      magnitude         <= '0;
      instruction_valid <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      state_q           <= state_next;
      instruction_valid <= emit;
      if (dir_load) dir_latched <= (data_in == CH_R);
      if (emit) begin
        direction <= dir_latched;
        magnitude <= emit_mag;
      end
      if (set_err)  error    <= 1'b1;
      if (set_ovf)  overflow <= 1'b1;
      if (set_done) done     <= 1'b1;
    end
  end

`ifdef DAY1_PARSER_STATS_EN
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) instruction_count <= '0;
    else if (emit) instruction_count <= instruction_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_day1_parser.sv
// tb_day1_parser: self-checking bench for day1_parser (MAX_DIGITS = 5).
module tb_day1_parser;
  import day1_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic        clock;
  logic        clear_n;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        data_in_last;
  logic        data_in_ready;
  logic        direction;
  logic [15:0] magnitude;
  logic        instruction_valid;
  logic        done;
  logic        error;
  logic        overflow;
  state_t      state_dbg;
`ifdef DAY1_PARSER_STATS_EN
  logic [31:0] instruction_count;
`endif

  day1_parser #(.MAX_DIGITS(5)) dut (
    .clock             (clock),
    .clear_n           (clear_n),
    .data_in           (data_in),
    .data_in_valid     (data_in_valid),
    .data_in_last      (data_in_last),
    .data_in_ready     (data_in_ready),
    .direction         (direction),
    .magnitude         (magnitude),
    .instruction_valid (instruction_valid),
    .done              (done),
    .error             (error),
    .overflow          (overflow),
`ifdef DAY1_PARSER_STATS_EN
    .instruction_count (instruction_count),
`endif
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (time %0t)", $time);
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];   // {direction, magnitude}
  int          pulse_cyc[$];
  int          exp_total;
  int          n_cmp  = 0;
  int          n_fail = 0;

  always @(negedge clock) begin
    if (clear_n && instruction_valid) begin
      pulse_cyc.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got dir=%0d mag=%0d, expected no pulse", direction, magnitude);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({direction, magnitude} !== e) begin
          n_fail++;
          $display("FAIL pulse: got dir=%0d mag=%0d, expected dir=%0d mag=%0d",
                   direction, magnitude, e[16], e[15:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Walks the stream line by line with plain integers; an error makes the
  // rest of the stream irrelevant.
  task automatic model(input byte_q_t s, input bit has_last, output bit e_err, output bit e_ovf);
    bit in_line = 0;
    bit bad = 0;
    bit dir = 0;
    int n = 0;
    int val = 0;
    e_ovf = 0;
    foreach (s[i]) begin
      if (!bad) begin
        if (!in_line) begin
          if (s[i] == "L" || s[i] == "R") begin
            in_line = 1; dir = (s[i] == "R"); n = 0; val = 0;
          end else if (s[i] != 8'h0A && s[i] != 8'h0D) bad = 1;
        end else begin
          if (s[i] >= "0" && s[i] <= "9") begin
            if (n == 5) bad = 1;
            else begin
              val = val * 10 + int'(s[i] - 8'h30);
              if (val > 65535) begin val = 65535; e_ovf = 1; end
              n++;
            end
          end else if (s[i] == 8'h0D) begin
          end else if (s[i] == 8'h0A) begin
            if (n > 0) begin
              exp_q.push_back({dir, 16'(val)}); exp_total++; in_line = 0;
            end else bad = 1;
          end else bad = 1;
        end
      end
    end
    if (has_last && !bad && in_line) begin
      if (n > 0) begin exp_q.push_back({dir, 16'(val)}); exp_total++; end
      else bad = 1;
    end
    e_err = bad;
  endtask

  // ---------------- drivers ----------------
  function automatic byte_q_t str_q(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic do_reset();
    data_in_valid = 0;
    data_in_last  = 0;
    data_in       = 8'h00;
    #2 clear_n    = 0;
    exp_q.delete();
    pulse_cyc.delete();
    exp_total = 0;
    repeat (2) @(posedge clock);
    #1 clear_n = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    if (!data_in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL ready: got data_in_ready=0 before byte %02h, expected 1", b);
    end
    data_in       = b;
    data_in_valid = 1;
    data_in_last  = last;
    @(posedge clock);
    #1;
    data_in_valid = 0;
    data_in_last  = 0;
  endtask

  // gaps: 0 none, 1 random idle cycles, 2 idle cycle between every byte
  task automatic send_stream(input byte_q_t s, input bit has_last, input int gaps);
    foreach (s[i]) begin
      if (gaps == 2 || (gaps == 1 && $urandom_range(0, 2) == 0)) begin
        @(posedge clock);
        #1;
      end
      send_byte(s[i], has_last && (i == s.size() - 1));
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", data_in_ready); end
    n_cmp++; if ({direction, magnitude} !== 17'd0) begin n_fail++; $display("FAIL reset_outputs: got dir=%0b mag=%0d expected 0/0", direction, magnitude); end
    n_cmp++; if ({instruction_valid, done, error, overflow} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %04b expected 0000", {instruction_valid, done, error, overflow}); end
    n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
  endtask

  task automatic test_basic();
    bit e_err, e_ovf;
    do_reset();
    model(str_q("L68\nR48\n"), 0, e_err, e_ovf);
    send_stream(str_q("L68\nR48\n"), 0, 0);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_missing: got %0d pulses outstanding, expected 0", exp_q.size()); end
    n_cmp++;
    if (pulse_cyc.size() != 2 || pulse_cyc[1] - pulse_cyc[0] != 4) begin
      n_fail++; $display("FAIL basic_spacing: got %0d pulses, expected 2 pulses 4 cycles apart", pulse_cyc.size());
    end
    n_cmp++; if ({error, overflow} !== {e_err, e_ovf}) begin n_fail++; $display("FAIL basic_flags: got err=%0b ovf=%0b expected %0b/%0b", error, overflow, e_err, e_ovf); end
  endtask

  task automatic test_back_to_back();
    bit e_err, e_ovf;
    do_reset();
    model(str_q("R1\nL2\n"), 0, e_err, e_ovf);
    send_stream(str_q("R1\nL2\n"), 0, 0);
    n_cmp++;
    if (exp_q.size() != 0 || pulse_cyc.size() != 2 || pulse_cyc[1] - pulse_cyc[0] != 3) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d pulses, expected 2 pulses 3 cycles apart", pulse_cyc.size());
    end
  endtask

  task automatic test_gapped();
    bit e_err, e_ovf;
    do_reset();
    model(str_q("R1000\r\n"), 0, e_err, e_ovf);
    send_stream(str_q("R1000\r\n"), 0, 2);
    n_cmp++; if (exp_q.size() != 0 || pulse_cyc.size() != 1) begin n_fail++; $display("FAIL gapped_count: got %0d pulses, expected 1", pulse_cyc.size()); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL gapped_error: got %0b expected 0", error); end
  endtask

  task automatic test_overflow();
    bit e_err, e_ovf;
    do_reset();
    model(str_q("L70000\n"), 0, e_err, e_ovf);
    send_stream(str_q("L70000\n"), 0, 0);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_missing: got %0d pulses outstanding, expected 0", exp_q.size()); end
    n_cmp++; if ({overflow, error} !== 2'b10) begin n_fail++; $display("FAIL ovf_flags: got ovf=%0b err=%0b expected 1/0", overflow, error); end
    n_cmp++; if (magnitude !== 16'hFFFF) begin n_fail++; $display("FAIL ovf_mag: got %0d expected 65535", magnitude); end
  endtask

  task automatic test_format_error();
    bit e_err, e_ovf;
    byte_q_t rest;
    do_reset();
    model(str_q("X5\nR3\n"), 0, e_err, e_ovf);
    send_byte("X", 0);
    n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_first: got error=%0b expected 1", error); end
    rest = str_q("5\nR3\n");
    send_stream(rest, 0, 0);
    n_cmp++; if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready: got %0b expected 1", data_in_ready); end
    n_cmp++; if (pulse_cyc.size() != 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL err_pulses: got %0d pulses expected 0", pulse_cyc.size()); end
    n_cmp++; if ({error, done} !== {e_err, 1'b0}) begin n_fail++; $display("FAIL err_flags: got err=%0b done=%0b expected %0b/0", error, done, e_err); end
  endtask

  task automatic test_last();
    bit e_err, e_ovf;
    do_reset();
    model(str_q("R7"), 1, e_err, e_ovf);
    send_stream(str_q("R7"), 1, 0);
    n_cmp++; if (exp_q.size() != 0 || pulse_cyc.size() != 1) begin n_fail++; $display("FAIL last_pulse: got %0d pulses expected 1", pulse_cyc.size()); end
    n_cmp++; if ({done, data_in_ready, error} !== 3'b100) begin n_fail++; $display("FAIL last_flags: got done/ready/err=%03b expected 100", {done, data_in_ready, error}); end
    do_reset();
    model(str_q("L\n"), 1, e_err, e_ovf);
    send_stream(str_q("L\n"), 1, 0);
    n_cmp++; if ({error, done} !== {e_err, 1'b1}) begin n_fail++; $display("FAIL last_empty: got err=%0b done=%0b expected %0b/1", error, done, e_err); end
    n_cmp++; if (pulse_cyc.size() != 0) begin n_fail++; $display("FAIL last_empty_pulse: got %0d pulses expected 0", pulse_cyc.size()); end
  endtask

  task automatic test_clear_mid();
    bit e_err, e_ovf;
    do_reset();
    send_byte("R", 0); send_byte("1", 0); send_byte("2", 0);
    do_reset();
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (pulse_cyc.size() != 0) begin n_fail++; $display("FAIL clear_pulse: got %0d pulses expected 0", pulse_cyc.size()); end
    n_cmp++;
    if ({direction, magnitude, instruction_valid, done, error, overflow, data_in_ready} !== {17'd0, 4'b0, 1'b1}) begin
      n_fail++; $display("FAIL clear_outputs: got dir=%0b mag=%0d flags=%04b ready=%0b expected reset values",
                         direction, magnitude, {instruction_valid, done, error, overflow}, data_in_ready);
    end
    model(str_q("L3\n"), 0, e_err, e_ovf);
    send_stream(str_q("L3\n"), 0, 0);
    n_cmp++; if (exp_q.size() != 0 || pulse_cyc.size() != 1) begin n_fail++; $display("FAIL clear_resume: got %0d pulses expected 1", pulse_cyc.size()); end
`ifdef DAY1_PARSER_STATS_EN
    n_cmp++; if (instruction_count !== 32'(exp_total)) begin n_fail++; $display("FAIL stats_count: got %0d expected %0d", instruction_count, exp_total); end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      byte_q_t s;
      bit has_last, e_err, e_ovf;
      int nlines;
      do_reset();
      nlines   = $urandom_range(1, 6);
      has_last = $urandom_range(0, 1);
      for (int l = 0; l < nlines; l++) begin
        int nd;
        s.push_back($urandom_range(0, 1) ? 8'h52 : 8'h4C);
        nd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 5);
        for (int d = 0; d < nd; d++) s.push_back(8'(8'h30 + $urandom_range(0, 9)));
        if ($urandom_range(0, 19) == 0) s.push_back(8'h3F);
        if ($urandom_range(0, 3) == 0) s.push_back(8'h0D);
        if (!(has_last && l == nlines - 1 && $urandom_range(0, 1))) s.push_back(8'h0A);
        if ($urandom_range(0, 7) == 0) s.push_back(8'h0A);
      end
      model(s, has_last, e_err, e_ovf);
      send_stream(s, has_last, 1);
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_missing it=%0d: got %0d pulses outstanding expected 0", it, exp_q.size()); end
      n_cmp++;
      if ({error, overflow, done} !== {e_err, e_ovf, has_last}) begin
        n_fail++; $display("FAIL rand_flags it=%0d: got err/ovf/done=%03b expected %03b", it, {error, overflow, done}, {e_err, e_ovf, has_last});
      end
`ifdef DAY1_PARSER_STATS_EN
      n_cmp++; if (instruction_count !== 32'(exp_total)) begin n_fail++; $display("FAIL rand_stats it=%0d: got %0d expected %0d", it, instruction_count, exp_total); end
`endif
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_n       = 1;
    data_in       = 8'h00;
    data_in_valid = 0;
    data_in_last  = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_gapped();
    test_overflow();
    test_format_error();
    test_last();
    test_clear_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
